fp_round_seq: RTL and testbench

//  Multi-cycle normalise/round sequencer for the FP adder back end. Takes the raw

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_round_seq_if.sv | 26 ++
 rtl/add1toval.sv | 8 +
 rtl/fp_round_seq.sv | 173 +++++++++++++++++
 tb/tb_fp_round_seq.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP adder back-end normalise/round sequencer.
package fp_pkg;

  localparam int unsigned MW_DEF = 10;
  localparam int unsigned EW_DEF = 5;

  // Field positions inside the working mantissa {carry, hidden, frac, guard}
  localparam int unsigned CARRY  = MW_DEF + 2;
  localparam int unsigned HIDDEN = MW_DEF + 1;
  localparam int unsigned GUARD  = 0;

  typedef enum logic [2:0] {
    StIdle,
    StNorm,
    StLshift,
    StRound,
    StExpInc,
    StDone
  } state_e;

endpackage

// File: rtl/fp_round_seq_if.sv
// Request/result bundle between the adder datapath and the round sequencer.
interface fp_round_seq_if #(
  parameter int unsigned MW = 10,
  parameter int unsigned EW = 5
);
  logic          start;
  logic [MW+2:0] raw_mant;
  logic          sticky;
  logic [EW-1:0] exp_in;
  logic          ready;
  logic          out_valid;
  logic [MW-1:0] frac_out;
  logic [EW-1:0] exp_out;
  logic          ovf;
  logic          zero;

  modport master (
    output start, raw_mant, sticky, exp_in,
    input  ready, out_valid, frac_out, exp_out, ovf, zero
  );

  modport slave (
    input  start, raw_mant, sticky, exp_in,
    output ready, out_valid, frac_out, exp_out, ovf, zero
  );
endinterface

// File: rtl/add1toval.sv
// 10-bit conditional incrementer: y = a + en, carry out in y[10].
module add1toval (
  input  logic [9:0]  a_i,
  input  logic        en_i,
  output logic [10:0] y_o
);
  assign y_o = {1'b0, a_i} + {10'b0, en_i};
endmodule

// File: rtl/fp_round_seq.sv
// Normalise / round-to-nearest-even / exponent fix-up sequencer sharing one incrementer.
module fp_round_seq
  import fp_pkg::*;
#(
  parameter int unsigned MW = MW_DEF,
  parameter int unsigned EW = EW_DEF
) (
  input logic          clk,
  input logic          rst_n,
  fp_round_seq_if.slave bus
);

  state_e        state_q, ret_q;
  logic [MW+2:0] m_q;
  logic          s_q;
  logic [EW-1:0] e_q;
  logic          ready_q, valid_q, ovf_q, zero_q;
  logic [MW-1:0] frac_q;
  logic [EW-1:0] exp_q;

  logic [MW-1:0] inc_a;
  logic          inc_en;
  logic [MW:0]   inc_y;
  logic          roundup;
  logic [MW+2:0] m_shl;
  logic [EW-1:0] e_dec, e_inc;

  assign roundup = m_q[GUARD] & (s_q | m_q[1]);
  assign m_shl   = {m_q[MW+1:0], 1'b0};
  assign e_dec   = e_q - 1'b1;
  assign e_inc   = inc_y[EW-1:0];

  // The incrementer is owned by ROUND or EXP_INC, never both in one cycle
  always_comb begin
    inc_a  = '0;
    inc_en = 1'b0;
    case (state_q)
      StRound: begin
        inc_a  = m_q[MW:1];
        inc_en = roundup;
      end
      StExpInc: begin
        inc_a  = MW'(e_q);
        inc_en = 1'b1;
      end
      default: ;
    endcase
  end

  add1toval u_inc (
    .a_i  (inc_a),
    .en_i (inc_en),
    .y_o  (inc_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ret_q   <= StRound;
      m_q     <= '0;
      s_q     <= 1'b0;
      e_q     <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      frac_q  <= '0;
      exp_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            m_q     <= bus.raw_mant;
            s_q     <= bus.sticky;
            e_q     <= bus.exp_in;
            state_q <= StNorm;
            ready_q <= 1'b0;
          end else begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        end
        StNorm: begin
          if (m_q == '0) begin
            frac_q  <= '0;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StDone;
          end else if (m_q[CARRY]) begin
            m_q     <= m_q >> 1;
            s_q     <= s_q | m_q[GUARD];
            ret_q   <= StRound;
            state_q <= StExpInc;
          end else if (!m_q[HIDDEN]) begin
            state_q <= StLshift;
          end else begin
            state_q <= StRound;
          end
        end
        StLshift: begin
          m_q <= m_shl;
          e_q <= e_dec;
          if (m_shl[HIDDEN]) begin
            state_q <= StRound;
          end else if (e_dec == '0) begin
            // Exponent exhausted before normalising: flush to zero
            frac_q  <= '0;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StRound: begin
          if (inc_y[MW]) begin
            m_q[MW:1] <= '0;
            ret_q     <= StDone;
            state_q   <= StExpInc;
          end else begin
            m_q[MW:1] <= inc_y[MW-1:0];
            frac_q    <= inc_y[MW-1:0];
            exp_q     <= e_q;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            valid_q   <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= StDone;
          end
        end
        StExpInc: begin
          e_q <= e_inc;
          if (&e_inc) begin
            frac_q  <= '0;
            exp_q   <= e_inc;
            ovf_q   <= 1'b1;
            zero_q  <= 1'b0;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StDone;
          end else if (ret_q == StDone) begin
            frac_q  <= m_q[MW:1];
            exp_q   <= e_inc;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StDone;
          end else begin
            state_q <= ret_q;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.frac_out  = frac_q;
  assign bus.exp_out   = exp_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_fp_round_seq.sv
// Directed scoreboard bench for fp_round_seq: rounding, shifts, ovf/zero, reset, back-to-back.
module tb_fp_round_seq;

  logic clk;
  logic rst_n;

  fp_round_seq_if #(.MW(10), .EW(5)) bus ();

  fp_round_seq #(.MW(10), .EW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] frac;
    logic [4:0] ex;
    logic       ovf;
    logic       zero;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called with time just after an edge and the DUT ready; returns in the DONE cycle.
  task automatic do_op(input string tag, input logic [12:0] raw, input logic s,
                       input logic [4:0] e, input logic [9:0] xf, input logic [4:0] xe,
                       input logic xo, input logic xz, input int xl);
    exp_t x;
    exp_t got;
    int   cyc;
    x.frac = xf;
    x.ex   = xe;
    x.ovf  = xo;
    x.zero = xz;
    x.lat  = xl;
    sb.push_back(x);
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.start    = 1'b1;
    bus.raw_mant = raw;
    bus.sticky   = s;
    bus.exp_in   = e;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc++;
    end while (bus.out_valid !== 1'b1 && cyc < 40);
    got = sb.pop_front();
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_frac"}, 32'(bus.frac_out), 32'(got.frac));
    chk({tag, "_exp"}, 32'(bus.exp_out), 32'(got.ex));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(got.ovf));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(got.zero));
    chk({tag, "_lat"}, 32'(cyc), 32'(got.lat));
    last = got;
  endtask

  // One cycle after DONE: pulse must be gone and results held.
  task automatic idle_chk(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_hold_frac"}, 32'(bus.frac_out), 32'(last.frac));
    chk({tag, "_hold_exp"}, 32'(bus.exp_out), 32'(last.ex));
  endtask

  initial begin
    int seen;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.raw_mant = '0;
    bus.sticky   = 1'b0;
    bus.exp_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_frac", 32'(bus.frac_out), 32'd0);
    chk("rst_exp", 32'(bus.exp_out), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("t1_norm", {1'b0, 1'b1, 10'h000, 1'b0}, 1'b0, 5'd15, 10'h000, 5'd15, 0, 0, 3);
    idle_chk("t1");
    do_op("t2_rcarry", {1'b1, 1'b1, 10'h3FF, 1'b1}, 1'b0, 5'd15, 10'h000, 5'd17, 0, 0, 5);
    idle_chk("t2");
    do_op("t3_tie_even", {1'b0, 1'b1, 10'h002, 1'b1}, 1'b0, 5'd15, 10'h002, 5'd15, 0, 0, 3);
    do_op("t3_tie_odd", {1'b0, 1'b1, 10'h003, 1'b1}, 1'b0, 5'd15, 10'h004, 5'd15, 0, 0, 3);
    do_op("t3_sticky", {1'b0, 1'b1, 10'h002, 1'b1}, 1'b1, 5'd15, 10'h003, 5'd15, 0, 0, 3);
    idle_chk("t3");
    do_op("t4_lshift", {1'b0, 1'b0, 10'h200, 1'b0}, 1'b0, 5'd15, 10'h000, 5'd14, 0, 0, 4);
    idle_chk("t4");
    do_op("t5_ovf", {1'b1, 1'b1, 10'h000, 1'b0}, 1'b0, 5'd30, 10'h000, 5'd31, 1, 0, 3);
    do_op("t5_zero", 13'h0000, 1'b0, 5'd15, 10'h000, 5'd0, 0, 1, 2);
    idle_chk("t5");
    do_op("t6_noguard", {1'b0, 1'b1, 10'h3FF, 1'b0}, 1'b1, 5'd9, 10'h3FF, 5'd9, 0, 0, 3);
    do_op("t7_shift3", {1'b0, 1'b0, 10'h080, 1'b1}, 1'b0, 5'd10, 10'h004, 5'd7, 0, 0, 6);
    do_op("t8_rsh_rnd", {1'b1, 1'b0, 10'h001, 1'b1}, 1'b0, 5'd15, 10'h001, 5'd16, 0, 0, 4);
    do_op("t10_flush", {1'b0, 1'b0, 10'h001, 1'b0}, 1'b0, 5'd3, 10'h000, 5'd0, 0, 1, 5);
    do_op("t9_rnd_ovf", {1'b0, 1'b1, 10'h3FF, 1'b1}, 1'b0, 5'd30, 10'h000, 5'd31, 1, 0, 4);
    idle_chk("t9");

    // Abort a long left-shift sequence with reset
    bus.start    = 1'b1;
    bus.raw_mant = {1'b0, 1'b0, 10'h001, 1'b0};
    bus.sticky   = 1'b0;
    bus.exp_in   = 5'd20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t11_rst_ready", 32'(bus.ready), 32'd1);
    chk("t11_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t11_rst_frac", 32'(bus.frac_out), 32'd0);
    chk("t11_rst_exp", 32'(bus.exp_out), 32'd0);
    chk("t11_rst_ovf", 32'(bus.ovf), 32'd0);
    chk("t11_rst_zero", 32'(bus.zero), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("t11_no_pulse", 32'(seen), 32'd0);

    do_op("t12_after_rst", {1'b0, 1'b1, 10'h155, 1'b0}, 1'b0, 5'd12, 10'h155, 5'd12, 0, 0, 3);
    idle_chk("t12");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
